// File: rtl/simon_engine.sv
// simon_engine: single-module Simon Says game engine.
// Holds the random sequence, blinks it back on the LEDs (faster each level),
// watches the player switches for clean one-hot presses, and runs the game FSM
// through idle, playback, input, pause, lose and win.
module simon_engine #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned ON_CYC      = 25_000_000,
  parameter int unsigned OFF_CYC     = 12_500_000,
  parameter int unsigned STEP_CYC    = 1_000_000,
  parameter int unsigned MIN_ON_CYC  = 5_000_000,
  parameter int unsigned TIMEOUT_CYC = 250_000_000,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CH_W-1:0]  rand_num,
  input  logic [N_CH-1:0]  sw,
  output logic [N_CH-1:0]  led,
  output logic [LEN_W-1:0] level,
  output logic [LEN_W-1:0] score,
  output logic             playing,
  output logic             game_over,
  output logic             win
);

  // Width of an index into the sequence store.
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Terminal counts for the gap/pause timer and the input timeout.
  localparam logic [31:0] LAST_OFF     = (OFF_CYC == 0) ? 32'd0 : 32'(OFF_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  // Level-1 on-time, already clamped to the floor, plus the per-level step.
  localparam logic [31:0] ON_INIT       = (ON_CYC > MIN_ON_CYC) ? 32'(ON_CYC) : 32'(MIN_ON_CYC);
  localparam logic [31:0] MIN_ON        = 32'(MIN_ON_CYC);
  localparam logic [31:0] STEP          = 32'(STEP_CYC);
  localparam logic [32:0] MIN_PLUS_STEP = 33'(MIN_ON_CYC) + 33'(STEP_CYC);

  // Alternating LED pattern shown on a win: bit 0 lit, bit 1 dark, ...
  function automatic logic [N_CH-1:0] alt_pattern();
    logic [N_CH-1:0] p;
    p = '0;
    for (int i = 0; i < int'(N_CH); i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [N_CH-1:0] WIN_PAT = alt_pattern();

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_PAUSE,
    S_LOSE,
    S_WIN
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  level_q, level_d;
  logic [LEN_W-1:0]  score_q, score_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       on_time_q, on_time_d;
  logic              win_phase_q, win_phase_d;
  logic [N_CH-1:0]   sw_prev_q, sw_prev_d;
  logic [CH_W-1:0]   mem_q [MAX_LEN];
  logic [CH_W-1:0]   mem_d [MAX_LEN];

  logic              sw_onehot;
  logic              press;
  logic              last_step;
  logic [CH_W-1:0]   cur_ch;
  logic [N_CH-1:0]   expect_led;
  logic [CH_W-1:0]   rand_fold;

  assign sw_prev_d = sw;

  assign level = level_q;
  assign score = score_q;

  // Decode the player switches, the current step's channel and the folded rng value.
  always_comb begin
    sw_onehot  = (sw != '0) && ((sw & (sw - N_CH'(1))) == '0);
    press      = (sw_prev_q == '0) && sw_onehot;
    last_step  = (idx_q == (level_q - LEN_W'(1)));
    cur_ch     = mem_q[idx_q[IDX_W-1:0]];
    expect_led = N_CH'(1) << cur_ch;
    rand_fold  = rand_num;
    if (32'(rand_num) >= 32'(N_CH)) begin
      rand_fold = rand_num - CH_W'(N_CH);
    end
  end

  // Game FSM: next state, datapath updates and the Moore-style outputs.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    score_d     = score_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    on_time_d   = on_time_q;
    win_phase_d = win_phase_q;
    mem_d       = mem_q;
    led         = '0;
    playing     = 1'b0;
    game_over   = 1'b0;
    win         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          level_d = '0;
          score_d = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        mem_d[level_q[IDX_W-1:0]] = rand_fold;
        level_d = level_q + LEN_W'(1);
        idx_d   = '0;
        timer_d = '0;
        // Each new level shortens the blink by one step, never below the floor.
        if (level_q == '0) begin
          on_time_d = ON_INIT;
        end else if (33'(on_time_q) > MIN_PLUS_STEP) begin
          on_time_d = on_time_q - STEP;
        end else begin
          on_time_d = MIN_ON;
        end
        state_d = S_SHOW_ON;
      end

      S_SHOW_ON: begin
        led = expect_led;
        if (timer_q == (on_time_q - 32'd1)) begin
          timer_d = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_SHOW_OFF: begin
        if (timer_q == LAST_OFF) begin
          timer_d = '0;
          if (last_step) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_INPUT: begin
        playing = 1'b1;
        led     = sw_onehot ? sw : '0;
        // A press on the timeout cycle still counts, so it is checked first.
        if (press) begin
          timer_d = '0;
          if (sw == expect_led) begin
            if (last_step) begin
              score_d     = level_q;
              win_phase_d = 1'b0;
              state_d     = (level_q == LEN_W'(MAX_LEN)) ? S_WIN : S_PAUSE;
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if ((TIMEOUT_CYC != 0) && (timer_q == TIMEOUT_LAST)) begin
          state_d = S_LOSE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_PAUSE: begin
        if (timer_q == LAST_OFF) begin
          timer_d = '0;
          state_d = S_ADD;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_LOSE: begin
        game_over = 1'b1;
        led       = '1;
        if (start) begin
          level_d = '0;
          score_d = '0;
          state_d = S_ADD;
        end
      end

      S_WIN: begin
        win = 1'b1;
        led = win_phase_q ? ~WIN_PAT : WIN_PAT;
        if (start) begin
          level_d = '0;
          score_d = '0;
          timer_d = '0;
          state_d = S_ADD;
        end else if (timer_q == LAST_OFF) begin
          timer_d     = '0;
          win_phase_d = ~win_phase_q;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wipes every piece of game state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      score_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      on_time_q   <= '0;
      win_phase_q <= 1'b0;
      sw_prev_q   <= '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      score_q     <= score_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      on_time_q   <= on_time_d;
      win_phase_q <= win_phase_d;
      sw_prev_q   <= sw_prev_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: self-checking bench for simon_engine with a small game model.
module tb_simon_engine;

  localparam int N_CH        = 4;
  localparam int MAX_LEN     = 3;
  localparam int ON_CYC      = 8;
  localparam int OFF_CYC     = 4;
  localparam int STEP_CYC    = 2;
  localparam int MIN_ON_CYC  = 5;
  localparam int TIMEOUT_CYC = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rand_num = 2'd0;
  logic [3:0] sw = 4'd0;
  logic [3:0] led;
  logic [1:0] level;
  logic [1:0] score;
  logic       playing;
  logic       game_over;
  logic       win;

  int n_cmp  = 0;
  int n_fail = 0;
  int seq[$];

  simon_engine #(
    .N_CH(N_CH),
    .MAX_LEN(MAX_LEN),
    .ON_CYC(ON_CYC),
    .OFF_CYC(OFF_CYC),
    .STEP_CYC(STEP_CYC),
    .MIN_ON_CYC(MIN_ON_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rand_num(rand_num),
    .sw(sw),
    .led(led),
    .level(level),
    .score(score),
    .playing(playing),
    .game_over(game_over),
    .win(win)
  );

  always #5 clk = ~clk;

  // Blink length for a level: linear speed-up clamped at the floor.
  function automatic int model_on_time(input int lvl);
    int t;
    t = ON_CYC - STEP_CYC * (lvl - 1);
    return (t < MIN_ON_CYC) ? MIN_ON_CYC : t;
  endfunction

  function automatic logic [3:0] onehot(input int ch);
    return 4'b0001 << ch;
  endfunction

  function automatic int fold(input int r);
    return (r >= N_CH) ? r - N_CH : r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse start with a fresh random first step; leaves the engine in its add cycle.
  task automatic new_game();
    int r;
    r = $urandom_range(0, 3);
    seq.delete();
    seq.push_back(fold(r));
    rand_num = 2'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({led, level, score, playing, game_over, win} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got led=%b level=%0d score=%0d flags=%b%b%b, want all 0",
               led, level, score, playing, game_over, win);
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({led, level, score, playing, game_over, win} !== 11'd0) begin
        n_fail++;
        $display("[TB] FAIL idle_quiet cyc%0d: got led=%b level=%0d score=%0d flags=%b%b%b, want all 0",
                 c, led, level, score, playing, game_over, win);
      end
    end
  endtask

  task automatic test_full_game();
    int r;
    logic [3:0] exp_led;
    new_game();
    n_cmp++;
    if ({led, level, playing} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL add_cycle: got led=%b level=%0d playing=%b, want 0/0/0", led, level, playing);
    end
    tick();
    for (int lvl = 1; lvl <= MAX_LEN; lvl++) begin
      n_cmp++;
      if (int'(level) !== lvl) begin
        n_fail++;
        $display("[TB] FAIL level_at_show: got %0d want %0d", level, lvl);
      end
      for (int s = 0; s < lvl; s++) begin
        for (int c = 0; c < model_on_time(lvl); c++) begin
          n_cmp++;
          if ({led, playing} !== {onehot(seq[s]), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL playback_on lvl%0d step%0d cyc%0d: got led=%b playing=%b, want led=%b playing=0",
                     lvl, s, c, led, playing, onehot(seq[s]));
          end
          tick();
        end
        for (int c = 0; c < OFF_CYC; c++) begin
          n_cmp++;
          if ({led, playing} !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL playback_off lvl%0d step%0d cyc%0d: got led=%b playing=%b, want 0/0",
                     lvl, s, c, led, playing);
          end
          tick();
        end
      end
      n_cmp++;
      if (playing !== 1'b1 || int'(level) !== lvl) begin
        n_fail++;
        $display("[TB] FAIL enter_input lvl%0d: got playing=%b level=%0d, want 1/%0d", lvl, playing, level, lvl);
      end
      if (lvl == MAX_LEN) begin
        // Multi-hot switches and a start pulse mid-input must do nothing.
        sw = 4'b0110;
        start = 1'b1;
        #1;
        n_cmp++;
        if (led !== 4'b0000) begin
          n_fail++;
          $display("[TB] FAIL multi_hot_led: got %b want 0000", led);
        end
        tick();
        n_cmp++;
        if ({playing, game_over, win} !== 3'b100 || int'(level) !== lvl) begin
          n_fail++;
          $display("[TB] FAIL multi_hot_no_event: got flags=%b%b%b level=%0d, want 100 level %0d",
                   playing, game_over, win, level, lvl);
        end
        sw = onehot((seq[0] + 1) % N_CH);
        #1;
        n_cmp++;
        if (led !== sw) begin
          n_fail++;
          $display("[TB] FAIL onehot_echo: got %b want %b", led, sw);
        end
        tick();
        n_cmp++;
        if ({playing, game_over, win} !== 3'b100) begin
          n_fail++;
          $display("[TB] FAIL no_event_without_release: got flags=%b%b%b want 100", playing, game_over, win);
        end
        sw = 4'b0000;
        start = 1'b0;
        tick();
      end
      for (int s = 0; s < lvl; s++) begin
        sw = onehot(seq[s]);
        #1;
        n_cmp++;
        if (led !== sw) begin
          n_fail++;
          $display("[TB] FAIL press_echo lvl%0d step%0d: got %b want %b", lvl, s, led, sw);
        end
        tick();
        if (s < lvl - 1) begin
          n_cmp++;
          if ({playing, game_over} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL mid_round lvl%0d step%0d: got playing=%b game_over=%b, want 1/0",
                     lvl, s, playing, game_over);
          end
          sw = 4'b0000;
          tick();
        end
      end
      sw = 4'b0000;
      n_cmp++;
      if (int'(score) !== lvl) begin
        n_fail++;
        $display("[TB] FAIL score_after_round: got %0d want %0d", score, lvl);
      end
      if (lvl < MAX_LEN) begin
        r = $urandom_range(0, 3);
        seq.push_back(fold(r));
        rand_num = 2'(r);
        for (int c = 0; c < OFF_CYC; c++) begin
          n_cmp++;
          if ({led, playing} !== 5'd0 || int'(score) !== lvl) begin
            n_fail++;
            $display("[TB] FAIL pause lvl%0d cyc%0d: got led=%b playing=%b score=%0d, want 0/0/%0d",
                     lvl, c, led, playing, score, lvl);
          end
          tick();
        end
        n_cmp++;
        if (led !== 4'b0000 || int'(level) !== lvl) begin
          n_fail++;
          $display("[TB] FAIL add_after_pause: got led=%b level=%0d, want 0000/%0d", led, level, lvl);
        end
        tick();
      end
    end
    n_cmp++;
    if ({win, game_over, playing} !== 3'b100 || int'(level) !== MAX_LEN || int'(score) !== MAX_LEN) begin
      n_fail++;
      $display("[TB] FAIL win_state: got flags=%b%b%b level=%0d score=%0d, want 100/%0d/%0d",
               win, game_over, playing, level, score, MAX_LEN, MAX_LEN);
    end
    for (int c = 0; c < 2 * OFF_CYC; c++) begin
      exp_led = (((c / OFF_CYC) % 2) == 0) ? 4'b0101 : 4'b1010;
      n_cmp++;
      if (led !== exp_led) begin
        n_fail++;
        $display("[TB] FAIL win_blink cyc%0d: got %b want %b", c, led, exp_led);
      end
      tick();
    end
  endtask

  task automatic test_wrong_press();
    int w;
    new_game();
    n_cmp++;
    if ({win, game_over} !== 2'b00 || level !== 2'd0 || score !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL restart_from_win: got win=%b game_over=%b level=%0d score=%0d, want 0/0/0/0",
               win, game_over, level, score);
    end
    tick();
    skip(model_on_time(1) + OFF_CYC);
    n_cmp++;
    if (playing !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrong_reach_input: got playing=%b want 1", playing);
    end
    w = (seq[0] + 1 + $urandom_range(0, 2)) % N_CH;
    sw = onehot(w);
    tick();
    sw = 4'b0000;
    n_cmp++;
    if ({game_over, playing, win, led} !== 7'b100_1111 || level !== 2'd1 || score !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL wrong_press_lose: got go=%b pl=%b win=%b led=%b level=%0d score=%0d, want 1/0/0/1111/1/0",
               game_over, playing, win, led, level, score);
    end
    skip(3);
    n_cmp++;
    if ({game_over, led} !== 5'b1_1111 || level !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL lose_held: got go=%b led=%b level=%0d, want 1/1111/1", game_over, led, level);
    end
  endtask

  task automatic test_timeout();
    new_game();
    n_cmp++;
    if (game_over !== 1'b0 || level !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL restart_from_lose: got game_over=%b level=%0d, want 0/0", game_over, level);
    end
    tick();
    skip(model_on_time(1) + OFF_CYC);
    for (int c = 0; c < TIMEOUT_CYC; c++) begin
      n_cmp++;
      if ({playing, game_over} !== 2'b10) begin
        n_fail++;
        $display("[TB] FAIL timeout_wait cyc%0d: got playing=%b game_over=%b, want 1/0", c, playing, game_over);
      end
      tick();
    end
    n_cmp++;
    if ({playing, game_over, led} !== 6'b01_1111) begin
      n_fail++;
      $display("[TB] FAIL timeout_lose: got playing=%b game_over=%b led=%b, want 0/1/1111",
               playing, game_over, led);
    end
  endtask

  task automatic test_reset_mid_game();
    int r;
    new_game();
    tick();
    skip(model_on_time(1) + OFF_CYC);
    sw = onehot(seq[0]);
    tick();
    sw = 4'b0000;
    r = $urandom_range(0, 3);
    seq.push_back(fold(r));
    rand_num = 2'(r);
    skip(OFF_CYC + 1);
    skip(2);
    n_cmp++;
    if (level !== 2'd2 || score !== 2'd1 || led !== onehot(seq[0])) begin
      n_fail++;
      $display("[TB] FAIL pre_reset: got level=%0d score=%0d led=%b, want 2/1/%b", level, score, led, onehot(seq[0]));
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({led, level, score, playing, game_over, win} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_clears: got led=%b level=%0d score=%0d flags=%b%b%b, want all 0",
               led, level, score, playing, game_over, win);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({led, level, score, playing, game_over, win} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got led=%b level=%0d score=%0d flags=%b%b%b, want all 0",
               led, level, score, playing, game_over, win);
    end
    new_game();
    tick();
    n_cmp++;
    if (led !== onehot(seq[0]) || level !== 2'd1 || score !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL restart_after_reset: got led=%b level=%0d score=%0d, want %b/1/0",
               led, level, score, onehot(seq[0]));
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_full_game();
    test_wrong_press();
    test_timeout();
    test_reset_mid_game();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case the run wanders off.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
